// File: rtl/a4l_master.sv
// -----------------------------------------------------------------------------
// a4l_master
//
// Single-outstanding AXI4-Lite master. A simple command/response handshake on
// the user side is turned into one AXI4-Lite write (AW + W + B) or read
// (AR + R) transaction. The AXI response and, for reads, the read data are
// returned on the response channel.
//
// Optional feature macro: A4LM_TIMEOUT_EN
//   Defined   -> a per-transaction cycle counter aborts a stalled transaction
//                after TIMEOUT_CYCLES cycles and reports RSP_RESP = 2'b11.
//   Undefined -> no counter and no abort path; the master waits for the slave
//                indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed per transaction before abort (timeout build)
//
// Ports
//   ACLK, ARESETN                      clock, asynchronous active-low reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA/WSTRB   command channel (user -> master)
//   RSP_VALID/READY/DATA/RESP                response channel (master -> user)
//   M_AXI_AW*, M_AXI_W*, M_AXI_B*            AXI4-Lite write channels
//   M_AXI_AR*, M_AXI_R*                      AXI4-Lite read channels
// -----------------------------------------------------------------------------
module a4l_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETN,

    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    input  logic [3:0]  CMD_WSTRB,

    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic [1:0]  RSP_RESP,

    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,

    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,

    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,

    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,

    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic        awvalid_reg, awvalid_next;
    logic        wvalid_reg, wvalid_next;
    logic        arvalid_reg, arvalid_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic [1:0]  rsp_resp_reg, rsp_resp_next;

    // AW/W channels may complete in either order or together; a channel is
    // done once its valid has dropped or it handshakes this cycle.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_reg || M_AXI_AWREADY;
    assign w_done  = !wvalid_reg  || M_AXI_WREADY;

`ifdef A4LM_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_reg, timer_next;
    logic          busy;
    assign busy = (state_reg == WADDR) || (state_reg == WRESP) ||
                  (state_reg == RADDR) || (state_reg == RDATA);
`else
    // Without the timeout feature the parameter keeps the interface identical
    // across builds; this empty block is its only reference.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
    end
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        awvalid_next  = awvalid_reg;
        wvalid_next   = wvalid_reg;
        arvalid_next  = arvalid_reg;
        rsp_data_next = rsp_data_reg;
        rsp_resp_next = rsp_resp_reg;
`ifdef A4LM_TIMEOUT_EN
        timer_next    = timer_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (CMD_VALID && cmd_ready_reg) begin
                    addr_next  = CMD_ADDR;
                    wdata_next = CMD_WDATA;
                    wstrb_next = CMD_WSTRB;
`ifdef A4LM_TIMEOUT_EN
                    timer_next = '0;
`endif
                    if (CMD_WRITE) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WADDR;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RADDR;
                    end
                end
            end
            WADDR: begin
                if (M_AXI_AWREADY) awvalid_next = 1'b0;
                if (M_AXI_WREADY)  wvalid_next  = 1'b0;
                if (aw_done && w_done) state_next = WRESP;
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    rsp_resp_next = M_AXI_BRESP;
                    rsp_data_next = 32'd0;
                    state_next    = RESP;
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_next = 1'b0;
                    state_next   = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    rsp_resp_next = M_AXI_RRESP;
                    rsp_data_next = M_AXI_RDATA;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

`ifdef A4LM_TIMEOUT_EN
        // Abort takes priority over any handshake landing on the same edge.
        if (busy) begin
            if (timer_reg == TIMER_LAST) begin
                awvalid_next  = 1'b0;
                wvalid_next   = 1'b0;
                arvalid_next  = 1'b0;
                rsp_resp_next = 2'b11;
                rsp_data_next = 32'd0;
                state_next    = RESP;
            end else begin
                timer_next = timer_reg + 1'b1;
            end
        end
`endif

        // Registered so CMD_READY stays low while reset is held, yet is high
        // on every cycle the FSM sits in IDLE.
        cmd_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            wstrb_reg     <= 4'd0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rsp_data_reg  <= 32'd0;
            rsp_resp_reg  <= 2'd0;
`ifdef A4LM_TIMEOUT_EN
            timer_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            arvalid_reg   <= arvalid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_resp_reg  <= rsp_resp_next;
`ifdef A4LM_TIMEOUT_EN
            timer_reg     <= timer_next;
`endif
        end
    end

    assign CMD_READY     = cmd_ready_reg;
    assign RSP_VALID     = (state_reg == RESP);
    assign RSP_DATA      = rsp_data_reg;
    assign RSP_RESP      = rsp_resp_reg;

    assign M_AXI_AWADDR  = addr_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = (state_reg == WRESP);
    assign M_AXI_ARADDR  = addr_reg;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_RREADY  = (state_reg == RDATA);

endmodule

// File: tb/tb_a4l_master.sv
// -----------------------------------------------------------------------------
// tb_a4l_master
//
// Directed bench for a4l_master. Inputs are driven and outputs sampled on the
// falling edge of ACLK; the DUT acts on the rising edge. Expected values are
// hand-derived constants. Built with or without A4LM_TIMEOUT_EN; the DUT runs
// with TIMEOUT_CYCLES = 16.
// -----------------------------------------------------------------------------
module tb_a4l_master;

    logic        ACLK;
    logic        ARESETN;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic [3:0]  CMD_WSTRB;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_DATA;
    logic [1:0]  RSP_RESP;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int tests_run = 0;
    int tests_failed = 0;
    int aw_hs = 0;
    int w_hs = 0;

    a4l_master #(.TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_RESP(RSP_RESP),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Handshake counters on the AXI write-address and write-data channels.
    always @(posedge ACLK) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs++;
        if (M_AXI_WVALID && M_AXI_WREADY) w_hs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
    endtask

    initial begin
        ARESETN = 1'b0;
        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0;
        RSP_READY = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RVALID = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
        chk("rst_axi_valids", {29'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'd0);
        chk("rst_axi_readys", {30'd0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
        chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        chk("rst_rsp_data", RSP_DATA, 32'd0);
        chk("rst_rsp_resp", {30'd0, RSP_RESP}, 32'd0);
        chk("prot", {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
        step(); step();
        ARESETN = 1'b1;
        #1;
        chk("rel_cmd_ready_pre_edge", {31'd0, CMD_READY}, 32'd0);
        step();
        chk("rel_cmd_ready_post_edge", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] reset checks done");

        // ---------------- write, AWREADY two cycles before WREADY ----------
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0000_0010;
        CMD_WDATA = 32'hCAFE_F00D; CMD_WSTRB = 4'hF;
        step();
        CMD_VALID = 1'b0;
        chk("w1_awvalid", {31'd0, M_AXI_AWVALID}, 32'd1);
        chk("w1_wvalid", {31'd0, M_AXI_WVALID}, 32'd1);
        chk("w1_awaddr", M_AXI_AWADDR, 32'h0000_0010);
        chk("w1_wdata", M_AXI_WDATA, 32'hCAFE_F00D);
        chk("w1_wstrb", {28'd0, M_AXI_WSTRB}, 32'hF);
        chk("w1_cmd_ready_busy", {31'd0, CMD_READY}, 32'd0);
        M_AXI_AWREADY = 1'b1;
        step();
        M_AXI_AWREADY = 1'b0;
        chk("w1_aw_dropped", {31'd0, M_AXI_AWVALID}, 32'd0);
        chk("w1_w_held", {31'd0, M_AXI_WVALID}, 32'd1);
        chk("w1_no_bready_yet", {31'd0, M_AXI_BREADY}, 32'd0);
        step();
        chk("w1_w_held2", {31'd0, M_AXI_WVALID}, 32'd1);
        chk("w1_wdata_stable", M_AXI_WDATA, 32'hCAFE_F00D);
        M_AXI_WREADY = 1'b1;
        step();
        M_AXI_WREADY = 1'b0;
        chk("w1_w_dropped", {31'd0, M_AXI_WVALID}, 32'd0);
        chk("w1_bready", {31'd0, M_AXI_BREADY}, 32'd1);
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        step();
        M_AXI_BVALID = 1'b0;
        chk("w1_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
        chk("w1_rsp_resp", {30'd0, RSP_RESP}, 32'd0);
        chk("w1_rsp_data", RSP_DATA, 32'd0);
        chk("w1_bready_off", {31'd0, M_AXI_BREADY}, 32'd0);
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("w1_rsp_done", {31'd0, RSP_VALID}, 32'd0);
        chk("w1_cmd_ready_back", {31'd0, CMD_READY}, 32'd1);
        chk("w1_aw_hs_count", aw_hs, 32'd1);
        chk("w1_w_hs_count", w_hs, 32'd1);
        $display("[TB] write 0x10 <- 0xCAFEF00D done resp=%0d", RSP_RESP);

        // ---------------- stray RVALID/BVALID in IDLE is ignored -------------
        M_AXI_RVALID = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_RDATA = 32'hDEAD_BEEF;
        step();
        M_AXI_RVALID = 1'b0; M_AXI_BVALID = 1'b0;
        chk("idle_stray_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        chk("idle_stray_readys", {30'd0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
        chk("idle_stray_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] stray slave responses in idle done");

        // ---------------- read with RSP_READY held off 5 cycles -------------
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0004;
        step();
        CMD_VALID = 1'b0;
        chk("r1_arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
        chk("r1_araddr", M_AXI_ARADDR, 32'h0000_0004);
        chk("r1_no_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
        M_AXI_ARREADY = 1'b1;
        step();
        M_AXI_ARREADY = 1'b0;
        chk("r1_ar_dropped", {31'd0, M_AXI_ARVALID}, 32'd0);
        chk("r1_rready", {31'd0, M_AXI_RREADY}, 32'd1);
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h1234_5678; M_AXI_RRESP = 2'b00;
        step();
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("r1_hold_valid", {31'd0, RSP_VALID}, 32'd1);
            chk("r1_hold_data", RSP_DATA, 32'h1234_5678);
            chk("r1_hold_resp", {30'd0, RSP_RESP}, 32'd0);
            chk("r1_hold_cmd_ready", {31'd0, CMD_READY}, 32'd0);
            if (i < 4) step();
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("r1_rsp_done", {31'd0, RSP_VALID}, 32'd0);
        chk("r1_cmd_ready_back", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] read 0x4 -> 0x12345678 done");

        // ---------------- write with AW/W same cycle, BRESP=SLVERR ----------
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0000_0020;
        CMD_WDATA = 32'h0000_55AA; CMD_WSTRB = 4'h3;
        step();                                   // sample 1 after accept
        CMD_VALID = 1'b0;
        chk("w2_both_valid", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        chk("w2_wstrb", {28'd0, M_AXI_WSTRB}, 32'h3);
        step();                                   // sample 2
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("w2_both_dropped", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
        chk("w2_bready", {31'd0, M_AXI_BREADY}, 32'd1);
        chk("w2_no_rsp_yet", {31'd0, RSP_VALID}, 32'd0);
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
        step();                                   // sample 3
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        chk("w2_rsp_valid_at_3", {31'd0, RSP_VALID}, 32'd1);
        chk("w2_rsp_resp", {30'd0, RSP_RESP}, 32'h2);
        chk("w2_rsp_data_zero", RSP_DATA, 32'd0);
        chk("w2_aw_hs_count", aw_hs, 32'd2);
        chk("w2_w_hs_count", w_hs, 32'd2);
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("w2_cmd_ready_back", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] write 0x20 slverr done resp=%0d", 2);

        // ---------------- read where slave never grants ARREADY -------------
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0040;
        step();
        CMD_VALID = 1'b0;
`ifdef A4LM_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            chk("to_arvalid_held", {31'd0, M_AXI_ARVALID}, 32'd1);
            step();
        end
        chk("to_arvalid_dropped", {31'd0, M_AXI_ARVALID}, 32'd0);
        chk("to_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
        chk("to_rsp_resp", {30'd0, RSP_RESP}, 32'h3);
        chk("to_rsp_data", RSP_DATA, 32'd0);
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("to_cmd_ready_back", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] read timeout done resp=3");
`else
        for (int i = 0; i < 40; i++) begin
            chk("wait_arvalid_held", {31'd0, M_AXI_ARVALID}, 32'd1);
            chk("wait_araddr_stable", M_AXI_ARADDR, 32'h0000_0040);
            step();
        end
        M_AXI_ARREADY = 1'b1;
        step();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hA5A5_0001; M_AXI_RRESP = 2'b01;
        step();
        M_AXI_RVALID = 1'b0;
        chk("wait_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
        chk("wait_rsp_data", RSP_DATA, 32'hA5A5_0001);
        chk("wait_rsp_resp", {30'd0, RSP_RESP}, 32'h1);
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("wait_cmd_ready_back", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] read with long ARREADY stall done");
`endif

        // ---------------- reset pulse while WRESP pending -------------------
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0000_0080;
        CMD_WDATA = 32'h1111_2222; CMD_WSTRB = 4'hF;
        step();
        CMD_VALID = 1'b0;
        step();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("rp_bready_pending", {31'd0, M_AXI_BREADY}, 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("rp_async_bready", {31'd0, M_AXI_BREADY}, 32'd0);
        chk("rp_async_cmd_ready", {31'd0, CMD_READY}, 32'd0);
        chk("rp_async_valids", {28'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, RSP_VALID}, 32'd0);
        chk("rp_async_rsp", {RSP_DATA[29:0], RSP_RESP}, 32'd0);
        step();
        ARESETN = 1'b1;
        step();
        chk("rp_cmd_ready_after", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0100;
        M_AXI_ARREADY = 1'b1;
        step();
        CMD_VALID = 1'b0;
        chk("rp_read_araddr", M_AXI_ARADDR, 32'h0000_0100);
        step();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h0BAD_F00D; M_AXI_RRESP = 2'b00;
        step();
        M_AXI_RVALID = 1'b0;
        chk("rp_read_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
        chk("rp_read_rsp_data", RSP_DATA, 32'h0BAD_F00D);
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("rp_read_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        $display("[TB] reset mid-transaction and recovery read done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
